// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array sizes and feeder state encoding
package systolic_pkg;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int SW = 10;
  localparam int FEED_CYC = 10;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE} state_t;
endpackage

// File: rtl/skew_lane.sv
// skew_lane: select the skewed matrix element for one operand lane at feed step t
module skew_lane
  import systolic_pkg::*;
#(
  parameter int IDX = 0,
  parameter bit COL = 1'b0
) (
  input  logic [N*N*DW-1:0] mat,
  input  logic [3:0]        t,
  input  logic              en,
  output logic [DW-1:0]     el
);
  logic [3:0] k;
  logic [3:0] sel;
  assign k = t - 4'(IDX);
  assign sel = COL ? {k[1:0], 2'(IDX)} : {2'(IDX), k[1:0]};
  assign el = (en && k <= 4'd3) ? mat[{sel, 2'b00} +: DW] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: sequence a 4x4 multiply through a systolic array and capture its sums
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [N*N*DW-1:0]   mat_a,
  input  logic [N*N*DW-1:0]   mat_b,
  output logic [DW-1:0]       a0,
  output logic [DW-1:0]       a1,
  output logic [DW-1:0]       a2,
  output logic [DW-1:0]       a3,
  output logic [DW-1:0]       b0,
  output logic [DW-1:0]       b1,
  output logic [DW-1:0]       b2,
  output logic [DW-1:0]       b3,
  output logic                arr_res,
  input  logic [N*N*SW-1:0]   sum_in,
  output logic [N*N*SW-1:0]   result,
  output logic                busy,
  output logic                done
);
  state_t state, nxt;
  logic [15:0] t, t_nxt;
  logic [N*N*DW-1:0] ra, rb;
  logic [DW-1:0] ae[N], be[N], ar[N], br[N];
  logic feed_nxt;
  always_comb begin
    nxt = state;
    t_nxt = t;
    case (state)
      IDLE: begin
        nxt = start ? CLEAR : IDLE;
        t_nxt = '0;
      end
      CLEAR: nxt = FEED;
      FEED: begin
        nxt = (t == 16'(FEED_CYC - 1)) ? (DRAIN_CYC == 0 ? CAPTURE : DRAIN) : FEED;
        t_nxt = (t == 16'(FEED_CYC - 1)) ? '0 : t + 16'd1;
      end
      DRAIN: begin
        nxt = (t == 16'(DRAIN_CYC - 1)) ? CAPTURE : DRAIN;
        t_nxt = (t == 16'(DRAIN_CYC - 1)) ? '0 : t + 16'd1;
      end
      CAPTURE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign feed_nxt = nxt == FEED;
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(.IDX(i), .COL(1'b0)) u_a (.mat(ra), .t(t_nxt[3:0]), .en(feed_nxt), .el(ae[i]));
    skew_lane #(.IDX(i), .COL(1'b1)) u_b (.mat(rb), .t(t_nxt[3:0]), .en(feed_nxt), .el(be[i]));
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      t <= '0;
      ar <= '{default: '0};
      br <= '{default: '0};
      result <= '0;
    end else begin
      state <= nxt;
      t <= t_nxt;
      ar <= ae;
      br <= be;
      if (state == CAPTURE) result <= sum_in;
      if (state == IDLE && start) begin
        ra <= mat_a;
        rb <= mat_b;
      end
    end
  end
  assign {a0, a1, a2, a3} = {ar[0], ar[1], ar[2], ar[3]};
  assign {b0, b1, b2, b3} = {br[0], br[1], br[2], br[3]};
  assign busy = state != IDLE;
  assign done = state == CAPTURE;
  assign arr_res = res || state == CLEAR;
endmodule
